// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the wait-FSM encoding, default timeout and the MEM/WB payload layout.
package mem_access_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    localparam int          DEFAULT_TIMEOUT = 16;
    localparam int          DEFAULT_CNT_W   = 5;
    localparam logic [31:0] LINK_OFFSET     = 32'd4;

    typedef struct packed {
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } memwb_t;

    // jalr targets are always halfword aligned: bit 0 of the sum is discarded
    function automatic logic [31:0] jalr_target(input logic [31:0] sum);
        return {sum[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
// rdata is only meaningful in the cycle ack is high.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage_wait_ctrl.sv
// Wait FSM for one data-memory access: zero-wait in IDLE, else WAIT until ack or TIMEOUT.
// Latency: complete fires in the ack cycle; stall is combinational and drops in that same cycle.
module mem_wait_ctrl
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op,
    input  logic ack,
    output logic req,
    output logic stall,
    output logic complete,
    output logic timeout,
    output logic in_wait
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    mem_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                req = mem_op;
                if (mem_op) begin
                    if (ack) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // the waiting op is the oldest in flight, so a flush never cancels it
                req = 1'b1;
                if (ack) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    complete  = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // a reset mid-access withdraws the request immediately
        if (rst) begin
            req      = 1'b0;
            stall    = 1'b0;
            complete = 1'b0;
            timeout  = 1'b0;
        end
    end

    assign in_wait = (state == ST_WAIT);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: resolves branches/jumps, runs the data-memory access and registers MEM/WB.
// Latency: one cycle to MEM/WB after completion; stall_out freezes upstream while the access waits.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic                       Ctl_MemtoReg_in,
    input  logic                       Ctl_RegWrite_in,
    input  logic                       Ctl_MemRead_in,
    input  logic                       Ctl_MemWrite_in,
    input  logic                       Ctl_Branch_in,
    input  logic                       jal_in,
    input  logic                       jalr_in,
    input  logic                       bne_in,
    input  logic                       Zero_in,
    input  logic [4:0]                 Rd_in,
    input  logic [31:0]                ALUresult_in,
    input  logic [31:0]                PCimm_in,
    input  logic [31:0]                ReadData2_in,
    input  logic [31:0]                PC_in,
    mem_access_stage_if.master         dmem,
    output logic                       stall_out,
    output logic                       PCSrc_out,
    output logic [31:0]                PCtarget_out,
    output logic                       flush_out,
    output logic                       err_out,
    output logic                       Ctl_MemtoReg_out,
    output logic                       Ctl_RegWrite_out,
    output logic [4:0]                 Rd_out,
    output logic [31:0]                ALUresult_out,
    output logic [31:0]                ReadData_out
);

    logic   mem_op;
    logic   req, stall, complete, timeout, in_wait;
    logic   taken, bubble;
    memwb_t memwb_d, memwb_q;

    assign mem_op = (Ctl_MemRead_in | Ctl_MemWrite_in) & ~flush_in;

    mem_wait_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_ctrl (
        .clk      (clk),
        .rst      (rst),
        .mem_op   (mem_op),
        .ack      (dmem.ack),
        .req      (req),
        .stall    (stall),
        .complete (complete),
        .timeout  (timeout),
        .in_wait  (in_wait)
    );

    // address, data and direction come straight from EX/MEM, which upstream holds during a stall
    assign dmem.req   = req;
    assign dmem.we    = ~rst & Ctl_MemWrite_in;
    assign dmem.addr  = ALUresult_in;
    assign dmem.wdata = ReadData2_in;
    assign stall_out  = stall;

    assign taken        = Ctl_Branch_in & (bne_in ? ~Zero_in : Zero_in);
    assign PCSrc_out    = ~rst & ~flush_in & (taken | jal_in | jalr_in);
    assign flush_out    = PCSrc_out;
    assign PCtarget_out = jalr_in ? jalr_target(ALUresult_in) : PCimm_in;

    always_comb begin
        memwb_d            = '0;
        memwb_d.memtoreg   = Ctl_MemtoReg_in;
        memwb_d.regwrite   = Ctl_RegWrite_in;
        memwb_d.rd         = Rd_in;
        memwb_d.alu_result = (jal_in | jalr_in) ? PC_in + LINK_OFFSET : ALUresult_in;
        memwb_d.read_data  = (Ctl_MemRead_in & complete & ~timeout) ? dmem.rdata : '0;
    end

    assign bubble = stall | (flush_in & ~in_wait);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb_q <= '0;
            err_out <= 1'b0;
        end else begin
            if (timeout) begin
                err_out <= 1'b1;
            end
            // bubbles only clear the control bits; stale data is harmless with RegWrite low
            if (bubble) begin
                memwb_q.regwrite <= 1'b0;
                memwb_q.memtoreg <= 1'b0;
            end else begin
                memwb_q <= memwb_d;
            end
        end
    end

    assign Ctl_MemtoReg_out = memwb_q.memtoreg;
    assign Ctl_RegWrite_out = memwb_q.regwrite;
    assign Rd_out           = memwb_q.rd;
    assign ALUresult_out    = memwb_q.alu_result;
    assign ReadData_out     = memwb_q.read_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed plan items, then random instructions against a transaction-level model.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in;
    logic        jal_in, jalr_in, bne_in, Zero_in;
    logic [4:0]  Rd_in;
    logic [31:0] ALUresult_in, PCimm_in, ReadData2_in, PC_in;
    logic        stall_out, PCSrc_out, flush_out, err_out;
    logic [31:0] PCtarget_out;
    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out;
    logic [4:0]  Rd_out;
    logic [31:0] ALUresult_out, ReadData_out;

    mem_access_stage_if dmem ();

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(T), .CNT_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_in         (flush_in),
        .Ctl_MemtoReg_in  (Ctl_MemtoReg_in),
        .Ctl_RegWrite_in  (Ctl_RegWrite_in),
        .Ctl_MemRead_in   (Ctl_MemRead_in),
        .Ctl_MemWrite_in  (Ctl_MemWrite_in),
        .Ctl_Branch_in    (Ctl_Branch_in),
        .jal_in           (jal_in),
        .jalr_in          (jalr_in),
        .bne_in           (bne_in),
        .Zero_in          (Zero_in),
        .Rd_in            (Rd_in),
        .ALUresult_in     (ALUresult_in),
        .PCimm_in         (PCimm_in),
        .ReadData2_in     (ReadData2_in),
        .PC_in            (PC_in),
        .dmem             (dmem),
        .stall_out        (stall_out),
        .PCSrc_out        (PCSrc_out),
        .PCtarget_out     (PCtarget_out),
        .flush_out        (flush_out),
        .err_out          (err_out),
        .Ctl_MemtoReg_out (Ctl_MemtoReg_out),
        .Ctl_RegWrite_out (Ctl_RegWrite_out),
        .Rd_out           (Rd_out),
        .ALUresult_out    (ALUresult_out),
        .ReadData_out     (ReadData_out)
    );

    typedef struct {
        logic        mr, mw, br, bne, zero, jal, jalr, flush, rw, m2r;
        logic [4:0]  rd;
        logic [31:0] alu, pcimm, wd2, pc, rdat;
        int          lat;
    } instr_t;

    int   checks   = 0;
    int   failures = 0;
    logic err_model = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        flush_in = 0; Ctl_MemtoReg_in = 0; Ctl_RegWrite_in = 0; Ctl_MemRead_in = 0;
        Ctl_MemWrite_in = 0; Ctl_Branch_in = 0; jal_in = 0; jalr_in = 0; bne_in = 0;
        Zero_in = 0; Rd_in = '0; ALUresult_in = '0; PCimm_in = '0; ReadData2_in = '0;
        PC_in = '0; dmem.ack = 0; dmem.rdata = '0;
    endtask

    // Present one instruction from posedge+1 until it retires; model works per instruction, not per state.
    task automatic do_instr(input instr_t in);
        logic        memop, taken, to, done;
        logic [31:0] tgt, alu_exp, rd_exp;
        int          nw;
        flush_in = in.flush; Ctl_MemtoReg_in = in.m2r; Ctl_RegWrite_in = in.rw;
        Ctl_MemRead_in = in.mr; Ctl_MemWrite_in = in.mw; Ctl_Branch_in = in.br;
        jal_in = in.jal; jalr_in = in.jalr; bne_in = in.bne; Zero_in = in.zero;
        Rd_in = in.rd; ALUresult_in = in.alu; PCimm_in = in.pcimm;
        ReadData2_in = in.wd2; PC_in = in.pc;

        memop   = (in.mr | in.mw) & ~in.flush;
        taken   = ~in.flush & ((in.br & (in.bne ? ~in.zero : in.zero)) | in.jal | in.jalr);
        tgt     = in.jalr ? (in.alu & 32'hFFFF_FFFE) : in.pcimm;
        nw      = memop ? ((in.lat > T) ? T : in.lat) : 0;
        to      = memop && (in.lat > T);
        alu_exp = (in.jal | in.jalr) ? in.pc + 32'd4 : in.alu;
        rd_exp  = (memop && in.mr && !to) ? in.rdat : 32'd0;
        done    = 1'b0;

        for (int k = 0; k <= T && !done; k++) begin
            dmem.ack   = memop ? (k == in.lat) : 1'($urandom);
            dmem.rdata = (memop && k == in.lat) ? in.rdat : $urandom;
            @(negedge clk);
            check1("req", dmem.req, memop);
            check1("stall", stall_out, memop && (k < nw));
            if (memop) begin
                check32("addr", dmem.addr, in.alu);
                check32("wdata", dmem.wdata, in.wd2);
                check1("we", dmem.we, in.mw);
            end
            check1("pcsrc", PCSrc_out, taken);
            check1("flush_out", flush_out, taken);
            if (taken) check32("target", PCtarget_out, tgt);
            @(posedge clk);
            #1;
            if (k < nw) begin
                check1("stall_bubble_rw", Ctl_RegWrite_out, 1'b0);
            end else begin
                done = 1'b1;
                err_model = err_model | to;
                check1("err", err_out, err_model);
                if (in.flush) begin
                    check1("flush_bubble_rw", Ctl_RegWrite_out, 1'b0);
                    check1("flush_bubble_m2r", Ctl_MemtoReg_out, 1'b0);
                end else begin
                    check1("rw_out", Ctl_RegWrite_out, in.rw);
                    check1("m2r_out", Ctl_MemtoReg_out, in.m2r);
                    check32("rd_out", 32'(Rd_out), 32'(in.rd));
                    check32("alu_out", ALUresult_out, alu_exp);
                    check32("rdata_out", ReadData_out, rd_exp);
                end
            end
        end
        dmem.ack = 1'b0;
    endtask

    function automatic instr_t blank();
        instr_t b;
        b = '{mr: 0, mw: 0, br: 0, bne: 0, zero: 0, jal: 0, jalr: 0, flush: 0, rw: 0, m2r: 0,
              rd: '0, alu: '0, pcimm: '0, wd2: '0, pc: '0, rdat: '0, lat: 0};
        return b;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        int     kind;
        r       = blank();
        kind    = $urandom_range(0, 5);
        r.rd    = 5'($urandom);
        r.alu   = $urandom; r.pcimm = $urandom; r.wd2 = $urandom;
        r.pc    = $urandom; r.rdat  = $urandom;
        r.flush = ($urandom_range(0, 5) == 0);
        r.lat   = $urandom_range(0, 4);
        if ($urandom_range(0, 9) == 0) r.lat = ($urandom_range(0, 1) == 0) ? T : T + 3;
        case (kind)
            0: begin r.mr = 1; r.rw = 1; r.m2r = 1; end
            1: begin r.mw = 1; end
            2: begin r.br = 1; r.bne = 1'($urandom); r.zero = 1'($urandom); end
            3: begin r.jal = 1; r.rw = 1; end
            4: begin r.jalr = 1; r.rw = 1; end
            default: begin r.rw = 1'($urandom); end
        endcase
        return r;
    endfunction

    initial begin
        instr_t i;

        // reset with a load and a jump presented: forced-low outputs
        drive_idle();
        Ctl_MemRead_in = 1; jal_in = 1;
        rst = 1'b1;
        #2;
        check1("rst_req", dmem.req, 1'b0);
        check1("rst_we", dmem.we, 1'b0);
        check1("rst_stall", stall_out, 1'b0);
        check1("rst_pcsrc", PCSrc_out, 1'b0);
        check1("rst_flush_out", flush_out, 1'b0);
        check1("rst_err", err_out, 1'b0);
        check1("rst_rw", Ctl_RegWrite_out, 1'b0);
        check32("rst_alu", ALUresult_out, 32'd0);
        check32("rst_rdata", ReadData_out, 32'd0);
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b0;

        // load, ack in the same cycle
        i = blank(); i.mr = 1; i.rw = 1; i.m2r = 1; i.rd = 5'd5;
        i.alu = 32'h40; i.rdat = 32'hDEAD_BEEF; i.lat = 0;
        do_instr(i);

        // store acked after 3 cycles
        i = blank(); i.mw = 1; i.alu = 32'h80; i.wd2 = 32'h1234_5678; i.lat = 3;
        do_instr(i);

        // bne taken / not taken
        i = blank(); i.br = 1; i.bne = 1; i.zero = 0; i.pcimm = 32'h100;
        do_instr(i);
        i.zero = 1;
        do_instr(i);

        // jalr: aligned target and link value
        i = blank(); i.jalr = 1; i.rw = 1; i.rd = 5'd1; i.alu = 32'h205; i.pc = 32'h80;
        do_instr(i);

        // jal link wraps at the top of the address space
        i = blank(); i.jal = 1; i.rw = 1; i.rd = 5'd2; i.pc = 32'hFFFF_FFFE; i.pcimm = 32'h44;
        do_instr(i);

        // load never acked: timeout after T stall cycles, sticky error
        i = blank(); i.mr = 1; i.rw = 1; i.m2r = 1; i.rd = 5'd7;
        i.alu = 32'h300; i.rdat = 32'hAAAA_5555; i.lat = 1000;
        do_instr(i);

        // flushed load: no request, bubble replaces the retired load's RegWrite
        i = blank(); i.mr = 1; i.rw = 1; i.flush = 1; i.alu = 32'h44; i.lat = 0;
        do_instr(i);

        for (int n = 0; n < 60; n++) begin
            do_instr(rand_instr());
        end

        // reset while waiting on a load
        drive_idle();
        Ctl_MemRead_in = 1; Ctl_RegWrite_in = 1; ALUresult_in = 32'h500;
        @(negedge clk);
        check1("pre_rst_stall", stall_out, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check1("wait_stall", stall_out, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("midwait_req", dmem.req, 1'b0);
        check1("midwait_stall", stall_out, 1'b0);
        check1("midwait_err", err_out, 1'b0);
        check1("midwait_rw", Ctl_RegWrite_out, 1'b0);
        check32("midwait_rd", 32'(Rd_out), 32'd0);
        err_model = 1'b0;
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b0;
        check1("post_rst_err", err_out, 1'b0);

        // an ALU op right after reset must see no request (FSM back in IDLE)
        i = blank(); i.rw = 1; i.rd = 5'd9; i.alu = 32'h77;
        do_instr(i);
        i = blank(); i.mr = 1; i.rw = 1; i.m2r = 1; i.alu = 32'h60; i.rdat = 32'h0BAD_F00D; i.lat = 2;
        do_instr(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
